// File: rtl/mem_reader_pkg.sv
// Shared types and default widths for the block reader.
package mem_reader_pkg;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 16;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_e;
endpackage

// File: rtl/mem_reader_fifo.sv
// Small synchronous FIFO holding returned words plus their last flag.
module mem_reader_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot in the same cycle, so push at full is fine then.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/mem_block_reader.sv
// Avalon-MM block read initiator: credit-limited issue, buffered stream out.
module mem_block_reader
    import mem_reader_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CR_W  = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

    state_e                  state_q;
    logic [ADDR_W-1:0]       ptr_q;
    logic [LEN_W-1:0]        remaining_q;
    logic [READ_LATENCY-1:0] pipe_q;
    logic [READ_LATENCY-1:0] last_pipe_q;
    logic                    done_q;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DATA_W:0]  fifo_rdata;
    logic [CR_W-1:0]  inflight;
    logic             issue;
    logic             push;
    logic             pop;
    logic             drained;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CR_W'(pipe_q[i]);
        end
    end

    // Every outstanding read owns a FIFO slot, so returns never overflow.
    assign issue = (state_q == READ) && (remaining_q != '0) && !fifo_full
                && ((CR_W'(fifo_count) + inflight) < CR_W'(FIFO_DEPTH));

    assign push    = pipe_q[READ_LATENCY-1];
    assign pop     = out_valid && out_ready;
    assign drained = (inflight == '0)
                  && (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            pipe_q      <= '0;
            last_pipe_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q         <= 1'b0;
            pipe_q[0]      <= issue;
            last_pipe_q[0] <= issue && (remaining_q == LEN_W'(1));
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i]      <= pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
            end
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        ptr_q       <= cmd_addr;
                        remaining_q <= cmd_len;
                        if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        ptr_q       <= ptr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_reader_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i ({last_pipe_q[READ_LATENCY-1], m_readdata}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign m_address    = ptr_q;
    assign m_chipselect = issue;
    assign m_write      = 1'b0;
    assign m_byteenable = BYTEEN_ALL;
    assign m_clken      = 1'b1;
    assign out_valid    = !fifo_empty;
    assign out_data     = out_valid ? fifo_rdata[DATA_W-1:0] : '0;
    assign out_last     = out_valid && fifo_rdata[DATA_W];
endmodule

// File: tb/tb_mem_block_reader.sv
// Randomised scoreboard bench for mem_block_reader.
module tb_mem_block_reader;
    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [AW-1:0] m_address;
    logic          m_chipselect;
    logic          m_write;
    logic [3:0]    m_byteenable;
    logic          m_clken;
    logic [DW-1:0] m_readdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    mem_block_reader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_byteenable (m_byteenable),
        .m_clken      (m_clken),
        .m_readdata   (m_readdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_total = 0;
    int rdy_pct = 100;
    int pend = 0;
    int out_cnt = 0;

    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            due_q[$];
    int            fv_q[$];

    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [DW:0]   e_word;
    bit            exp_cs;

    logic [DW-1:0] ram [1<<AW];

    function automatic logic [DW-1:0] ref_word(input int a);
        return 32'hA000_0000 + DW'(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (m_chipselect) m_readdata <= ram[m_address];
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            addr_q.delete();
            due_q.delete();
            fv_q.delete();
            pend       = 0;
            out_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (due_q.size() > 0 && cyc == due_q[0]) begin
                chk("done_pulse", done, 1);
                void'(due_q.pop_front());
                if (pend > 0) pend--;
            end else if (done) begin
                chk("done_unexpected", done, 0);
            end
            chk("busy", busy, pend > 0);
            chk("cmd_ready", cmd_ready, pend == 0);

            exp_cs = (addr_q.size() > 0) && (out_cnt < DEPTH);
            chk("chipselect", m_chipselect, exp_cs);
            if (m_chipselect && addr_q.size() > 0) begin
                chk("m_address", m_address, addr_q.pop_front());
                chk("m_write", m_write, 0);
                chk("m_byteenable", m_byteenable, 4'hF);
                chk("m_clken", m_clken, 1);
            end

            if (fv_q.size() > 0) begin
                if (cyc == fv_q[0] - 1) begin
                    chk("first_valid_early", out_valid, 0);
                end else if (cyc == fv_q[0]) begin
                    chk("first_valid", out_valid, 1);
                    void'(fv_q.pop_front());
                end
            end

            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {out_last, out_data}, {prev_last, prev_data});
            end

            if (out_valid && out_ready) begin
                hs_total++;
                if (exp_q.size() == 0) begin
                    chk("stream_extra", out_valid, 0);
                end else begin
                    e_word = exp_q.pop_front();
                    chk("stream_word", {out_last, out_data}, e_word);
                    if (e_word[DW]) due_q.push_back(cyc + 1);
                end
            end

            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (m_chipselect) out_cnt++;
            if (out_valid && out_ready) out_cnt--;
        end
    end

    task automatic issue_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l,
                             output bit done_seen);
        int n;
        bit ok;
        ok        = 1'b0;
        n         = 0;
        done_seen = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready && reset_n) begin
                ok        = 1'b1;
                n         = cyc;
                done_seen = done;
            end
        end
        @(posedge clk);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL cmd_accept: no acceptance within 3000 cycles");
        end else begin
            for (int k = 0; k < int'(l); k++) begin
                addr_q.push_back(AW'((int'(a) + k) % (1 << AW)));
                exp_q.push_back({k == int'(l) - 1,
                                 ref_word((int'(a) + k) % (1 << AW))});
            end
            if (l == '0) begin
                due_q.push_back(n + 1);
            end else begin
                pend++;
                fv_q.push_back(n + 3);
            end
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            ok = (pend == 0) && (exp_q.size() == 0) && (due_q.size() == 0)
              && (addr_q.size() == 0);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL idle_wait: pend %0d words %0d left", pend, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_chipselect", m_chipselect, 0);
        chk("rst_m_address", m_address, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_byteenable", m_byteenable, 4'hF);
        chk("rst_clken", m_clken, 1);
    endtask

    initial begin
        bit d;
        int base;
        int lens[3];
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'hA000_0000 + 32'(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        rdy_pct = 100;
        issue_cmd(15'd16, 16'd8, d);
        wait_idle();

        rdy_pct = 30;
        issue_cmd(AW'($urandom_range(0, 30000)), 16'd20, d);
        wait_idle();

        rdy_pct = 100;
        issue_cmd(15'd100, 16'd0, d);
        wait_idle();

        issue_cmd(15'h7FFE, 16'd4, d);
        wait_idle();

        base = hs_total;
        issue_cmd(15'd40, 16'd10, d);
        for (int i = 0; i < 200 && hs_total < base + 3; i++) @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        issue_cmd(15'd0, 16'd2, d);
        wait_idle();

        issue_cmd(15'd200, 16'd6, d);
        issue_cmd(15'd300, 16'd5, d);
        chk("accept_on_done", d, 1);
        wait_idle();

        lens = '{30, 70, 100};
        repeat (25) begin
            rdy_pct = lens[$urandom_range(0, 2)];
            issue_cmd(AW'($urandom_range(0, (1 << AW) - 1)),
                      LW'($urandom_range(0, 12)), d);
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
